fpu8_op_scheduler: RTL and testbench

Shares one 8-bit FPU arithmetic core between two requesters using round-robin arbitration.
- Each accepted operation is screened by an internal `EXCEPTION_MODULE` instance before launch.
- Operations that raise an exception return a canned NaN without occupying the core.
- Clean operations are launched with a start/done handshake and guarded by a timeout.
- Sits between the issue logic and the FPU core.

---
 rtl/fpu8_pkg.sv | 44 ++++
 rtl/EXCEPTION_MODULE.sv | 26 ++
 rtl/fpu8_op_scheduler_rr_arbiter2.sv | 35 +++
 rtl/fpu8_op_scheduler.sv | 142 ++++++++++++++
 tb/tb_fpu8_op_scheduler.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu8_pkg.sv
// Shared definitions for the 8-bit FPU scheduling slice: op codes, NaN encoding,
// exception codes, scheduler state and the captured-request record.
package fpu8_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    // 1-4-3 format: all-ones exponent and mantissa is the only NaN encoding
    localparam logic [7:0] NAN_0 = 8'h7F;

    localparam logic [2:0] EXC_NONE      = 3'd0;
    localparam logic [2:0] EXC_NAN_IN    = 3'd1;
    localparam logic [2:0] EXC_DIV_ZERO  = 3'd2;
    localparam logic [2:0] EXC_INVALID   = 3'd3;
    localparam logic [2:0] EXC_OVERFLOW  = 3'd4;
    localparam logic [2:0] EXC_UNDERFLOW = 3'd5;
    localparam logic [2:0] EXC_TIMEOUT   = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_EXEC,
        S_WAIT,
        S_RESP
    } sched_state_t;

    typedef struct packed {
        logic       id;
        logic [1:0] op;
        logic [7:0] in0;
        logic [7:0] in1;
    } sched_req_t;

    function automatic logic is_nan(input logic [7:0] v);
        return v[6:0] == 7'h7F;
    endfunction

    function automatic logic is_zero(input logic [7:0] v);
        return v[6:0] == 7'h00;
    endfunction

endpackage

// File: rtl/EXCEPTION_MODULE.sv
// Pre-launch operand screen: flags NaN inputs and division by zero so the
// scheduler can answer without occupying the arithmetic core.
module EXCEPTION_MODULE
    import fpu8_pkg::*;
(
    input  logic [1:0] op,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    output logic       exc,
    output logic [2:0] exc_code
);

    always_comb begin
        exc      = 1'b0;
        exc_code = EXC_NONE;
        if (is_nan(in0) || is_nan(in1)) begin
            exc      = 1'b1;
            exc_code = EXC_NAN_IN;
        end else if (op == OP_DIV && is_zero(in1)) begin
            // 0/0 has no meaningful value, x/0 is a plain divide-by-zero
            exc      = 1'b1;
            exc_code = is_zero(in0) ? EXC_INVALID : EXC_DIV_ZERO;
        end
    end

endmodule

// File: rtl/fpu8_op_scheduler_rr_arbiter2.sv
// Two-way round-robin grant; the pointer remembers the last served requester
// and only moves when the scheduler finishes an operation.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_id,
    output logic [1:0] grant,
    output logic       grant_id
);

    logic last;

    always_comb begin
        grant    = 2'b00;
        grant_id = 1'b0;
        if (req == 2'b11) begin
            grant_id = ~last;
            grant    = last ? 2'b01 : 2'b10;
        end else if (req[1]) begin
            grant_id = 1'b1;
            grant    = 2'b10;
        end else if (req[0]) begin
            grant    = 2'b01;
        end
    end

    // reset to 1 so requester 0 wins the first contested grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   last <= 1'b1;
        else if (upd) last <= upd_id;
    end

endmodule

// File: rtl/fpu8_op_scheduler.sv
// Shares one 8-bit FPU core between two requesters: round-robin accept, operand
// screening, single-pulse launch with timeout, and a registered response.
module fpu8_op_scheduler
    import fpu8_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [3:0]  req_op,
    input  logic [15:0] req_in0,
    input  logic [15:0] req_in1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [7:0]  rsp_result,
    output logic        rsp_exc,
    output logic [2:0]  rsp_exc_code,
    output logic        ex_start,
    output logic [1:0]  ex_op,
    output logic [7:0]  ex_in0,
    output logic [7:0]  ex_in1,
    input  logic        ex_done,
    input  logic [7:0]  ex_result,
    input  logic [2:0]  ex_flags,
    output logic [7:0]  exc_count
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    sched_state_t   state;
    sched_req_t     cap;
    logic [CW-1:0]  cnt;
    logic [1:0]     grant;
    logic           grant_id;
    logic           chk_exc;
    logic [2:0]     chk_code;
    logic           rsp_hs;

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req_valid),
        .upd      (rsp_hs),
        .upd_id   (rsp_id),
        .grant    (grant),
        .grant_id (grant_id)
    );

    EXCEPTION_MODULE u_exc (
        .op       (cap.op),
        .in0      (cap.in0),
        .in1      (cap.in1),
        .exc      (chk_exc),
        .exc_code (chk_code)
    );

    // gated by rst_n so every output reads zero while reset is held
    assign req_ready = (state == S_IDLE && rst_n) ? grant : 2'b00;
    assign rsp_hs    = (state == S_RESP) && rsp_ready;

    assign ex_op  = cap.op;
    assign ex_in0 = cap.in0;
    assign ex_in1 = cap.in1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cap          <= '0;
            cnt          <= '0;
            ex_start     <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= 8'h00;
            rsp_exc      <= 1'b0;
            rsp_exc_code <= EXC_NONE;
            exc_count    <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|grant) begin
                        cap.id  <= grant_id;
                        cap.op  <= req_op[{grant_id, 1'b0} +: 2];
                        cap.in0 <= req_in0[{grant_id, 3'b000} +: 8];
                        cap.in1 <= req_in1[{grant_id, 3'b000} +: 8];
                        state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (chk_exc) begin
                        rsp_valid    <= 1'b1;
                        rsp_id       <= cap.id;
                        rsp_result   <= NAN_0;
                        rsp_exc      <= 1'b1;
                        rsp_exc_code <= chk_code;
                        state        <= S_RESP;
                    end else begin
                        ex_start <= 1'b1;
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    ex_start <= 1'b0;
                    cnt      <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // ex_done takes priority over an expiring counter
                    if (ex_done) begin
                        rsp_valid    <= 1'b1;
                        rsp_id       <= cap.id;
                        rsp_result   <= ex_result;
                        rsp_exc      <= (ex_flags != EXC_NONE);
                        rsp_exc_code <= ex_flags;
                        state        <= S_RESP;
                    end else if (cnt == CW'(TIMEOUT)) begin
                        rsp_valid    <= 1'b1;
                        rsp_id       <= cap.id;
                        rsp_result   <= NAN_0;
                        rsp_exc      <= 1'b1;
                        rsp_exc_code <= EXC_TIMEOUT;
                        state        <= S_RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (rsp_exc && exc_count != 8'hFF)
                            exc_count <= exc_count + 8'd1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu8_op_scheduler.sv
// Directed bench for fpu8_op_scheduler with a latency-programmable core model.
module tb_fpu8_op_scheduler;
    import fpu8_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [3:0]  req_op = 4'h0;
    logic [15:0] req_in0 = 16'h0;
    logic [15:0] req_in1 = 16'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_id;
    logic [7:0]  rsp_result;
    logic        rsp_exc;
    logic [2:0]  rsp_exc_code;
    logic        ex_start;
    logic [1:0]  ex_op;
    logic [7:0]  ex_in0;
    logic [7:0]  ex_in1;
    logic        ex_done;
    logic [7:0]  ex_result;
    logic [2:0]  ex_flags;
    logic [7:0]  exc_count;

    logic        core_done = 1'b0;
    logic        stale_done = 1'b0;
    logic [7:0]  core_res = 8'h00;
    logic [2:0]  core_flg = 3'd0;
    int          core_lat = 0;

    int n_cmp = 0;
    int n_err = 0;
    int n_start = 0;
    int n_both = 0;
    int cyc = 0;
    int s0;

    assign ex_done   = core_done | stale_done;
    assign ex_result = core_res;
    assign ex_flags  = core_flg;

    fpu8_op_scheduler #(.TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_in0(req_in0), .req_in1(req_in1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_exc(rsp_exc), .rsp_exc_code(rsp_exc_code),
        .ex_start(ex_start), .ex_op(ex_op), .ex_in0(ex_in0), .ex_in1(ex_in1),
        .ex_done(ex_done), .ex_result(ex_result), .ex_flags(ex_flags),
        .exc_count(exc_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ex_start) n_start++;
        if (req_ready == 2'b11) n_both++;
    end

    // core model: done pulse core_lat cycles after a seen start; 0 = never answers
    initial begin
        forever begin
            @(posedge clk); #2;
            if (ex_start && core_lat > 0) begin
                repeat (core_lat) @(posedge clk);
                #2 core_done = 1'b1;
                @(posedge clk); #2 core_done = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
        cyc++;
    endtask

    // presents one request and returns #1 after the accept edge (cycle 1)
    task automatic issue(input int id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int w = 0;
        req_op[2*id +: 2]  = op;
        req_in0[8*id +: 8] = a;
        req_in1[8*id +: 8] = b;
        req_valid[id]      = 1'b1;
        #1;
        while (!req_ready[id] && w < 20) begin step(); w++; end
        chk("issue_grant", req_ready[id], 1'b1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_rsp();
        int w = 0;
        while (!rsp_valid && w < 40) begin step(); w++; end
        chk("rsp_arrive", rsp_valid, 1'b1);
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_ex_start", ex_start, 1'b0);
        chk("rst_exc_count", exc_count, 8'h00);
        rst_n = 1'b1;
        step();

        // exception path: NaN operand never reaches the core
        s0 = n_start;
        issue(0, OP_ADD, NAN_0, 8'h00);
        chk("exc_c1_valid", rsp_valid, 1'b0);
        step();
        chk("exc_c2_valid", rsp_valid, 1'b1);
        chk("exc_id", rsp_id, 1'b0);
        chk("exc_result", rsp_result, NAN_0);
        chk("exc_flag", rsp_exc, 1'b1);
        chk("exc_code", rsp_exc_code, EXC_NAN_IN);
        step();
        chk("exc_done_valid", rsp_valid, 1'b0);
        chk("exc_count1", exc_count, 8'd1);
        chk("exc_no_start", n_start - s0, 0);

        // normal path: MUL 1.0 x 2.0, core answers 3 cycles after start
        core_lat = 3; core_res = 8'h40; core_flg = 3'd0;
        s0 = n_start;
        issue(1, OP_MUL, 8'h38, 8'h40);
        step();
        chk("mul_start", ex_start, 1'b1);
        chk("mul_op", ex_op, OP_MUL);
        chk("mul_in0", ex_in0, 8'h38);
        chk("mul_in1", ex_in1, 8'h40);
        repeat (3) step();
        chk("mul_c5_valid", rsp_valid, 1'b0);
        step();
        chk("mul_c6_valid", rsp_valid, 1'b1);
        chk("mul_id", rsp_id, 1'b1);
        chk("mul_result", rsp_result, 8'h40);
        chk("mul_exc", rsp_exc, 1'b0);
        step();
        chk("mul_one_start", n_start - s0, 1);
        chk("mul_exc_count", exc_count, 8'd1);

        // arbitration: both requesters held valid
        core_lat = 1; core_res = 8'h48;
        req_op = {OP_SUB, OP_ADD};
        req_in0 = 16'h3838; req_in1 = 16'h3838;
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            int w = 0;
            #1;
            while (req_ready == 2'b00 && w < 20) begin step(); w++; end
            chk("arb_grant", req_ready, (i % 2) ? 2'b10 : 2'b01);
            @(posedge clk); #1;
            wait_rsp();
            chk("arb_rsp_id", rsp_id, (i % 2) ? 1'b1 : 1'b0);
            chk("arb_result", rsp_result, 8'h48);
            step();
        end
        req_valid = 2'b00;
        chk("arb_never_both", n_both, 0);
        step();

        // timeout with backpressure and a stale done during the stall
        core_lat = 0;
        rsp_ready = 1'b0;
        issue(0, OP_ADD, 8'h38, 8'h38);
        repeat (17) step();
        chk("to_c18_valid", rsp_valid, 1'b0);
        step();
        chk("to_c19_valid", rsp_valid, 1'b1);
        chk("to_result", rsp_result, NAN_0);
        chk("to_exc", rsp_exc, 1'b1);
        chk("to_code", rsp_exc_code, EXC_TIMEOUT);
        core_res = 8'h55;
        for (int i = 0; i < 5; i++) begin
            stale_done = (i == 1);
            step();
            chk("bp_valid", rsp_valid, 1'b1);
            chk("bp_id", rsp_id, 1'b0);
            chk("bp_result", rsp_result, NAN_0);
            chk("bp_code", rsp_exc_code, EXC_TIMEOUT);
        end
        stale_done = 1'b0;
        rsp_ready = 1'b1;
        step();
        chk("to_hs_valid", rsp_valid, 1'b0);
        chk("to_exc_count", exc_count, 8'd2);
        stale_done = 1'b1;
        step();
        stale_done = 1'b0;
        step();
        chk("stale_idle_valid", rsp_valid, 1'b0);
        chk("stale_idle_start", ex_start, 1'b0);

        // done arriving on the last wait cycle beats the timeout
        core_lat = 16; core_res = 8'h48; core_flg = 3'd0;
        issue(0, OP_MUL, 8'h38, 8'h48);
        repeat (17) step();
        chk("edge_c18_valid", rsp_valid, 1'b0);
        step();
        chk("edge_c19_valid", rsp_valid, 1'b1);
        chk("edge_result", rsp_result, 8'h48);
        chk("edge_exc", rsp_exc, 1'b0);
        step();
        chk("edge_exc_count", exc_count, 8'd2);

        // reset mid-WAIT
        core_lat = 0;
        issue(1, OP_SUB, 8'h40, 8'h38);
        repeat (4) step();
        req_op = {OP_SUB, OP_ADD};
        req_in0 = 16'h4038; req_in1 = 16'h3838;
        req_valid = 2'b11;
        #1 rst_n = 1'b0;
        #1;
        chk("mr_req_ready", req_ready, 2'b00);
        chk("mr_rsp_valid", rsp_valid, 1'b0);
        chk("mr_rsp_result", rsp_result, 8'h00);
        chk("mr_ex_start", ex_start, 1'b0);
        chk("mr_ex_in0", ex_in0, 8'h00);
        chk("mr_exc_count", exc_count, 8'h00);
        core_lat = 1; core_res = 8'h38;
        @(posedge clk); #1 rst_n = 1'b1;
        #1;
        chk("mr_first_grant", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_rsp();
        chk("mr_rsp_id", rsp_id, 1'b0);
        chk("mr_result", rsp_result, 8'h38);
        step();
        chk("mr_exc_count_end", exc_count, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
